// File: rtl/cmp32_seq.sv
// Iterative magnitude comparator: one nibble per cycle from LSB to MSB, a more
// significant differing nibble overrides the running verdict. Registered flags.
module cmp32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             less
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sgn_r;
  logic [IW-1:0]    idx;
  logic             gt_acc;
  logic             eq_acc;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       an;
  logic [3:0]       bn;
  logic             gt_n;
  logic             eq_n;

  // Flipping the sign bit of the top nibble turns a two's-complement compare
  // into an unsigned one, so the same nibble comparator serves both modes.
  always_comb begin
    a_sh = a_r >> {idx, 2'b00};
    b_sh = b_r >> {idx, 2'b00};
    an   = a_sh[3:0];
    bn   = b_sh[3:0];
    if (idx == LAST && sgn_r) begin
      an[3] = ~an[3];
      bn[3] = ~bn[3];
    end
    gt_n = gt_acc;
    eq_n = eq_acc;
    if (an > bn) begin
      gt_n = 1'b1;
      eq_n = 1'b0;
    end else if (an < bn) begin
      gt_n = 1'b0;
      eq_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
      less    <= 1'b0;
      gt_acc  <= 1'b0;
      eq_acc  <= 1'b0;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sgn_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          // FIN accepts a new request exactly like IDLE for back-to-back use.
          done <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            sgn_r  <= is_signed;
            idx    <= '0;
            gt_acc <= 1'b0;
            eq_acc <= 1'b1;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          gt_acc <= gt_n;
          eq_acc <= eq_n;
          if (idx == LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            greater <= gt_n;
            equal   <= eq_n;
            less    <= ~gt_n & ~eq_n;
            state   <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp32_seq.sv
// Bench for cmp32_seq: directed and random compares against an arithmetic
// model, plus handshake, back-to-back and mid-compare reset scenarios.
module tb_cmp32_seq;

  localparam int W   = 32;
  localparam int NIB = W / 4;
  localparam int LAT = NIB + 1;  // edges from the accepting edge to done, inclusive

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic         busy;
  logic         done;
  logic         greater;
  logic         equal;
  logic         less;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  cmp32_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .greater   (greater),
    .equal     (equal),
    .less      (less)
  );

  always #5 clk = ~clk;

  // Reference: {greater, equal, less} from plain integer comparison.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if (x == y) return 3'b010;
      return 3'b001;
    end
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Launch one compare from IDLE and wait for done; scribbles on the inputs after
  // acceptance. lat counts edges from the accepting one to the one raising done.
  task automatic do_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic ts, output int lat, output logic [2:0] flags);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; is_signed = ts;
    exp_q.push_back(ref_flags(ta, tb_v, ts));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~ts;
    lat = 1;
    while (!done && lat < 3 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    flags = {greater, equal, less};
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = '1; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, greater, equal, less} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 00000", {busy, done, greater, equal, less});
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_equality;
    int lat; logic [2:0] f, e;
    do_compare(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, lat, f);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++; $display("FAIL eq_latency: got %0d want %0d", lat, LAT);
    end
    n_cmp++;
    if (f !== e) begin
      n_bad++; $display("FAIL eq_flags: got %b want %b", f, e);
    end
    // Flags hold and done stays low until the next completion.
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, greater, equal, less} !== {1'b0, e}) begin
      n_bad++; $display("FAIL eq_hold: got %b want %b", {done, greater, equal, less}, {1'b0, e});
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va[7];
    logic [W-1:0] vb[7];
    logic         vs[7];
    int lat; logic [2:0] f, e;
    va = '{32'h10000000, 32'h0FFFFFFF, 32'h80000000, 32'h80000000,
           32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vb = '{32'h0FFFFFFF, 32'h10000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
           32'h00000000, 32'h00000000, 32'h00000001};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_compare(va[i], vb[i], vs[i], lat, f);
      e = exp_q.pop_front();
      n_cmp++;
      if (f !== e || lat !== LAT) begin
        n_bad++;
        $display("FAIL directed_%0d: a=%h b=%h s=%b got flags=%b lat=%0d want flags=%b lat=%0d",
                 i, va[i], vb[i], vs[i], f, lat, e, LAT);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic rs;
    int lat; logic [2:0] f, e;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, W - 1));
        2:       rb = {~ra[W-1:W-4], ra[W-5:0]};
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_compare(ra, rb, rs, lat, f);
      e = exp_q.pop_front();
      n_cmp++;
      if (f !== e || lat !== LAT) begin
        n_bad++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got flags=%b lat=%0d want flags=%b lat=%0d",
                 i, ra, rb, rs, f, lat, e, LAT);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat; logic [2:0] f, e;
    @(negedge clk);
    start = 1'b1; a = 32'h00000005; b = 32'h00000009; is_signed = 1'b0;
    exp_q.push_back(ref_flags(32'h00000005, 32'h00000009, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'h90000000; b = 32'h00000005; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 3 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    f = {greater, equal, less};
    e = exp_q.pop_front();
    n_cmp++;
    if (f !== e || lat !== LAT) begin
      n_bad++;
      $display("FAIL ignore_start: got flags=%b lat=%0d want flags=%b lat=%0d", f, lat, e, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [2:0] f, e;
    do_compare(32'h00000003, 32'h00000007, 1'b0, lat, f);
    e = exp_q.pop_front();
    n_cmp++;
    if (f !== e) begin
      n_bad++; $display("FAIL b2b_first: got %b want %b", f, e);
    end
    // Now inside the FIN cycle: request the next compare immediately.
    start = 1'b1; a = 32'hFFFFFFFE; b = 32'h00000002; is_signed = 1'b1;
    exp_q.push_back(ref_flags(32'hFFFFFFFE, 32'h00000002, 1'b1));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_busy: got busy,done=%b want 10", {busy, done});
    end
    lat = 1;
    while (!done && lat < 3 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    f = {greater, equal, less};
    e = exp_q.pop_front();
    n_cmp++;
    if (f !== e || lat !== LAT) begin
      n_bad++;
      $display("FAIL b2b_second: got flags=%b lat=%0d want flags=%b lat=%0d", f, lat, e, LAT);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [2:0] f, e;
    bit saw_done;
    @(negedge clk);
    start = 1'b1; a = 32'h00000001; b = 32'h00000000; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, greater, equal, less} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b want 00000", {busy, done, greater, equal, less});
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    saw_done = 1'b0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_done: got activity=%b want 0", saw_done);
    end
    do_compare(32'h7FFFFFFF, 32'h80000000, 1'b1, lat, f);
    e = exp_q.pop_front();
    n_cmp++;
    if (f !== e || lat !== LAT) begin
      n_bad++;
      $display("FAIL reset_recover: got flags=%b lat=%0d want flags=%b lat=%0d", f, lat, e, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_equality;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp32_seq.md
# cmp32_seq

Iterative 32-bit magnitude comparator for the MIPS datapath's multi-cycle compare path (slt/sltu and compare-based branches). It accepts two operands with a start/done handshake and compares them one 4-bit nibble per cycle, scanning from LSB to MSB. Each more-significant nibble that differs overrides the running result. Registered greater/equal/less flags are returned after a fixed latency.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4; NIB = WIDTH/4 nibble steps
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; sampled when start is accepted
- b  input  WIDTH  operand B; sampled when start is accepted
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse; greater/equal/less updated in the same cycle
- greater  output  1  A > B for the last completed compare
- equal  output  1  A == B for the last completed compare
- less  output  1  A < B for the last completed compare

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1:
  - latch a, b and is_signed into internal registers
  - set idx=0, gt_acc=0, eq_acc=1
  - go to RUN
- RUN, once per cycle on nibble n = idx:
  - an = A[4n+3:4n], bn = B[4n+3:4n]
  - if n == NIB-1 and signed: invert bit 3 of both an and bn (sign-bias trick)
  - an > bn: gt_acc=1, eq_acc=0
  - an < bn: gt_acc=0, eq_acc=0
  - an == bn: accumulators unchanged
  - idx increments; after processing n = NIB-1, go to FIN
- FIN (one cycle):
  - done=1
  - greater=gt_acc, equal=eq_acc, less=~gt_acc&~eq_acc
  - next state is IDLE
  - start=1 in FIN is accepted exactly as in IDLE, allowing back-to-back compares
- busy=1 in RUN; busy=0 in IDLE and FIN.
- start while busy=1 is ignored. The latched operands are not disturbed.
- Input changes on a/b/is_signed after acceptance have no effect on the current compare.
- Exactly one of greater/equal/less is high after the first completion. All three hold their value until the next done.
- idx is log2(NIB) bits wide and does not wrap within a compare. idx is not reset while in IDLE.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0
  - greater=0, equal=0, less=0
  - accumulators cleared
- Start accepted at edge k:
  - busy=1 for cycles k+1 through k+NIB (8 cycles at default)
  - done=1 and results valid in cycle k+NIB+1
  - Latency = NIB+1 edges from acceptance to done (9 at default).
- Back-to-back: with start=1 during FIN, the next busy begins the following cycle. Sustained throughput is one compare per NIB+1 cycles.
- Reset asserted mid-compare:
  - abort on that edge; no done pulse
  - outputs return to reset values
  - start held during reset is ignored
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Equality: a=b=0xDEADBEEF, is_signed=0. Expect done exactly 9 cycles after acceptance, with equal=1, greater=0, less=0.
- Override direction: a=0x10000000, b=0x0FFFFFFF, unsigned. The low nibbles favour B and the top nibble favours A, so expect greater=1. Swapping the operands gives less=1.
- Sign handling: a=0x80000000, b=0x7FFFFFFF. With is_signed=0 expect greater=1; with is_signed=1 expect less=1. Also check a=0xFFFFFFFF (−1), b=0x00000000, signed: expect less=1.
- LSB-only difference: a=0x00000001, b=0x00000000, unsigned. Expect greater=1.
- Handshake:
  - Pulse start again mid-RUN with different operands: it must be ignored, and the result matches the first operands.
  - start=1 in the FIN cycle launches a second compare: busy rises the next cycle and done arrives 9 cycles later.
- Reset: assert reset 3 cycles into RUN. Expect busy=0, done=0 and all flags 0 next cycle, with no done pulse. A subsequent compare must complete normally.
